ltsm_sb_handshake: RTL

Parametrised sideband request/response handshake engine for LTSM states, generalising the SBINIT done-req/done-resp exchange. On enable it sends a local request and answers the partner's request, with response-over-request priority. It reports completion when its own response is sent and the partner's response is received, and flags a timeout otherwise. It sits between an LTSM state controller (SBINIT, MBINIT sub-states, …) and the sideband message encoder/decoder.

---
 rtl/ltsm_sb_handshake_pkg.sv | 31 +++
 rtl/ltsm_sb_handshake_if.sv | 31 +++
 rtl/ltsm_sb_handshake_timeout_counter.sv | 38 +++
 rtl/ltsm_sb_handshake.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/ltsm_sb_handshake_pkg.sv
// Shared LTSM sideband types: handshake state encoding, flag bundle and
// the default SBINIT message codes.
package ltsm_sb_pkg;

   localparam int SB_MSG_WIDTH_DEFAULT = 4;

   localparam logic [SB_MSG_WIDTH_DEFAULT-1:0] SBINIT_OUT_OF_RESET = 4'd1;
   localparam logic [SB_MSG_WIDTH_DEFAULT-1:0] SBINIT_DONE_REQ     = 4'd2;
   localparam logic [SB_MSG_WIDTH_DEFAULT-1:0] SBINIT_DONE_RESP    = 4'd3;

   typedef enum logic [2:0] {
      HS_IDLE    = 3'd0,
      HS_ACTIVE  = 3'd1,
      HS_GUARD   = 3'd2,
      HS_DONE    = 3'd3,
      HS_TIMEOUT = 3'd4
   } ltsm_hs_state_e;

   typedef struct packed {
      logic req_sent;
      logic resp_sent;
      logic p_req;
      logic p_resp;
   } hs_flags_t;

   // States in which the exchange is still running and time is being charged.
   function automatic logic hs_in_progress(input ltsm_hs_state_e st);
      return (st == HS_ACTIVE) || (st == HS_GUARD);
   endfunction

endpackage

// File: rtl/ltsm_sb_handshake_if.sv
// Controller/codec-facing signals of the sideband handshake engine.
// Handshake: o_valid and i_msg_valid are single-cycle strobes with no back-pressure;
// i_SB_Busy=1 forbids starting a new send, and a code is only meaningful while its strobe is 1.
interface ltsm_sb_handshake_if #(
   parameter int SB_MSG_WIDTH = 4
);
   import ltsm_sb_pkg::*;

   logic                    i_en;
   logic [SB_MSG_WIDTH-1:0] i_req_code;
   logic [SB_MSG_WIDTH-1:0] i_resp_code;
   logic                    i_SB_Busy;
   logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg;
   logic                    i_msg_valid;
   logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg;
   logic                    o_valid;
   logic                    o_done;
   logic                    o_timeout;
   ltsm_hs_state_e          dbg_state;

   modport master (
      output i_en, i_req_code, i_resp_code, i_SB_Busy, i_decoded_SB_msg, i_msg_valid,
      input  o_encoded_SB_msg, o_valid, o_done, o_timeout, dbg_state
   );

   modport slave (
      input  i_en, i_req_code, i_resp_code, i_SB_Busy, i_decoded_SB_msg, i_msg_valid,
      output o_encoded_SB_msg, o_valid, o_done, o_timeout, dbg_state
   );

endinterface

// File: rtl/ltsm_sb_handshake_timeout_counter.sv
// Saturating cycle counter shared by LTSM states; expired holds once the
// count reaches TIMEOUT_CYCLES-1 until cleared.
module ltsm_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_clr) begin
         cnt_d = '0;
      end else if (i_en && (cnt_q != LAST)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_expired = (cnt_q == LAST);

endmodule

// File: rtl/ltsm_sb_handshake.sv
// Sideband done-req/done-resp exchange engine: sends the local request, answers
// the partner request (response first), and reports done or timeout.
module ltsm_sb_handshake
   import ltsm_sb_pkg::*;
#(
   parameter int SB_MSG_WIDTH   = 4,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int GUARD_CYCLES   = 2
) (
   input logic           i_clk,
   input logic           i_rst_n,
   ltsm_sb_handshake_if.slave sb
);

   localparam int GW = $clog2(GUARD_CYCLES + 1);
   localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

   ltsm_hs_state_e state_q, state_d;
   hs_flags_t      flags_q, flags_d;
   logic [GW-1:0]  guard_cnt_q, guard_cnt_d;

   logic                    o_valid_q, o_valid_d;
   logic [SB_MSG_WIDTH-1:0] o_code_q, o_code_d;
   logic                    o_done_q, o_timeout_q;

   logic send_req, send_resp, send_any;
   logic rx_req, rx_resp;
   logic hs_complete, guard_done, to_expired;

   ltsm_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_clr     ((state_q == HS_IDLE) || !sb.i_en),
      .i_en      (hs_in_progress(state_q)),
      .o_expired (to_expired)
   );

   // Completion looks at registered flags, so done follows the last flag update by one edge.
   assign hs_complete = flags_q.req_sent && flags_q.resp_sent && flags_q.p_resp;
   assign guard_done  = (guard_cnt_q == GUARD_LAST);
   assign send_any    = send_req || send_resp;

   assign rx_req  = (state_q != HS_IDLE) && sb.i_msg_valid &&
                    (sb.i_decoded_SB_msg == sb.i_req_code);
   assign rx_resp = (state_q != HS_IDLE) && sb.i_msg_valid &&
                    (sb.i_decoded_SB_msg == sb.i_resp_code);

   // State register.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= HS_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; done beats timeout, timeout beats a pending send.
   always_comb begin
      state_d = state_q;
      if (!sb.i_en) begin
         state_d = HS_IDLE;
      end else begin
         unique case (state_q)
            HS_IDLE: state_d = HS_ACTIVE;
            HS_ACTIVE: begin
               if (hs_complete)     state_d = HS_DONE;
               else if (to_expired) state_d = HS_TIMEOUT;
               else if (send_any)   state_d = HS_GUARD;
            end
            HS_GUARD: begin
               if (hs_complete)                      state_d = HS_DONE;
               else if (to_expired)                  state_d = HS_TIMEOUT;
               else if (guard_done && !sb.i_SB_Busy) state_d = HS_ACTIVE;
            end
            HS_DONE:    state_d = HS_DONE;
            HS_TIMEOUT: state_d = HS_TIMEOUT;
            default:    state_d = HS_IDLE;
         endcase
      end
   end

   // Output logic: send selection and the transmit code.
   always_comb begin
      send_req  = 1'b0;
      send_resp = 1'b0;
      o_valid_d = 1'b0;
      o_code_d  = '0;
      if ((state_q == HS_ACTIVE) && sb.i_en && !hs_complete && !to_expired &&
          !sb.i_SB_Busy) begin
         if (flags_q.p_req && !flags_q.resp_sent) begin
            send_resp = 1'b1;
         end else if (!flags_q.req_sent) begin
            send_req = 1'b1;
         end
      end
      if (send_resp) begin
         o_valid_d = 1'b1;
         o_code_d  = sb.i_resp_code;
      end else if (send_req) begin
         o_valid_d = 1'b1;
         o_code_d  = sb.i_req_code;
      end
   end

   always_comb begin
      flags_d = flags_q;
      if ((state_q == HS_IDLE) || !sb.i_en) begin
         flags_d = '0;
      end else begin
         if (send_req)  flags_d.req_sent  = 1'b1;
         if (send_resp) flags_d.resp_sent = 1'b1;
         if (rx_req)    flags_d.p_req     = 1'b1;
         if (rx_resp)   flags_d.p_resp    = 1'b1;
      end
   end

   always_comb begin
      guard_cnt_d = guard_cnt_q;
      if ((state_q == HS_IDLE) || send_any) begin
         guard_cnt_d = '0;
      end else if ((state_q == HS_GUARD) && !guard_done) begin
         guard_cnt_d = guard_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         flags_q     <= '0;
         guard_cnt_q <= '0;
         o_valid_q   <= 1'b0;
         o_code_q    <= '0;
         o_done_q    <= 1'b0;
         o_timeout_q <= 1'b0;
      end else begin
         flags_q     <= flags_d;
         guard_cnt_q <= guard_cnt_d;
         o_valid_q   <= o_valid_d;
         o_code_q    <= o_code_d;
         o_done_q    <= (state_d == HS_DONE);
         o_timeout_q <= (state_d == HS_TIMEOUT);
      end
   end

   assign sb.o_valid          = o_valid_q;
   assign sb.o_encoded_SB_msg = o_code_q;
   assign sb.o_done           = o_done_q;
   assign sb.o_timeout        = o_timeout_q;
   assign sb.dbg_state        = state_q;

endmodule
